// File: rtl/tsn_gate_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tsn_gate_sched
//  Purpose  : Time-aware (802.1Qbv style) egress gate scheduler. A gate
//             control list (GCL) cycles per-queue gate masks with per-slot
//             durations. Whenever the single-entry staging register is empty,
//             the highest-priority queue that is both non-empty and gate-open
//             is popped, and its bufferID is staged for the GMII serializer.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          : clock, asynchronous active-low reset
//    q_empty / q_rden    : per-queue show-ahead FIFO empty flag / pop strobe
//    q_data              : per-queue head bufferID, queue i at [16i+15:16i]
//    empty_metadata      : staging register empty (to serializer)
//    rden_metadata       : serializer pop of the staged bufferID
//    data_metadata       : staged bufferID
//    cfg_wren/addr/wdata : GCL write port, wdata = {gate_mask[3:0], duration}
//    cfg_len             : number of active GCL entries (clamped to 1..NGCL)
//    cfg_enable          : 1 = run the GCL, 0 = all gates open
//    gate_state          : effective gate mask
//    cnt_sched           : bufferIDs staged since reset (wrapping)
// ============================================================================
module tsn_gate_sched #(
    parameter int NQ   = 4,
    parameter int NGCL = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NQ-1:0]       q_empty,
    output logic [NQ-1:0]       q_rden,
    input  logic [16*NQ-1:0]    q_data,
    output logic                empty_metadata,
    input  logic                rden_metadata,
    output logic [15:0]         data_metadata,
    input  logic                cfg_wren,
    input  logic [2:0]          cfg_addr,
    input  logic [19:0]         cfg_wdata,
    input  logic [3:0]          cfg_len,
    input  logic                cfg_enable,
    output logic [NQ-1:0]       gate_state,
    output logic [31:0]         cnt_sched
);

    localparam logic [3:0]  c_len_max   = 4'(NGCL);
    localparam logic [19:0] c_gcl_reset = {4'hF, 16'd0};

    typedef enum logic [0:0] {
        ST_DISABLED = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [2:0]         idx_q;
    logic [15:0]        timer_q;
    logic [NQ-1:0]      gate_q;
    logic [19:0]        gcl_q [NGCL];

    logic [NQ-1:0]      rden_q;
    logic               full_q;
    logic [15:0]        data_q;
    logic [31:0]        cnt_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [3:0]         w_len_eff;
    logic               w_wrap;
    logic [2:0]         idx_d;
    logic [19:0]        w_entry0;
    logic [19:0]        w_next_entry;
    logic [NQ-1:0]      w_e0_mask;
    logic [NQ-1:0]      w_next_mask;
    logic [NQ-1:0]      sel_d;
    logic [15:0]        w_cap_data;
    logic               w_can_pick;

    // cfg_len is only consulted here, i.e. at slot-advance decisions.
    assign w_len_eff    = (cfg_len == 4'd0)      ? 4'd1      :
                          (cfg_len > c_len_max)  ? c_len_max : cfg_len;
    // ">=" rather than "==" so a shrinking cfg_len never strands the index
    // beyond the new list end.
    assign w_wrap       = (({1'b0, idx_q} + 4'd1) >= w_len_eff);
    assign idx_d        = w_wrap ? 3'd0 : (idx_q + 3'd1);
    assign w_entry0     = gcl_q[0];
    assign w_next_entry = gcl_q[idx_d];

    // The GCL carries 4 mask bits; any queues beyond the fourth stay open.
    for (genvar gi = 0; gi < NQ; gi++) begin : g_mask
        if (gi < 4) begin : g_ctl
            assign w_e0_mask[gi]   = w_entry0[16+gi];
            assign w_next_mask[gi] = w_next_entry[16+gi];
        end else begin : g_open
            assign w_e0_mask[gi]   = 1'b1;
            assign w_next_mask[gi] = 1'b1;
        end
    end

    // Highest-index eligible queue wins: later loop iterations override.
    always_comb begin
        sel_d = '0;
        for (int i = 0; i < NQ; i++) begin
            if (!q_empty[i] && gate_q[i]) begin
                sel_d    = '0;
                sel_d[i] = 1'b1;
            end
        end
    end

    // Head data of the queue being popped this cycle.
    always_comb begin
        w_cap_data = '0;
        for (int i = 0; i < NQ; i++) begin
            if (rden_q[i]) begin
                w_cap_data = q_data[16*i +: 16];
            end
        end
    end

    // A new pop is only launched when the stage is empty and no pop is
    // already in flight (the in-flight pop fills the stage next edge).
    assign w_can_pick = !full_q && (rden_q == '0);

    // ------------------------------------------------------------------
    // Gate control list storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NGCL; e++) begin
                gcl_q[e] <= c_gcl_reset;
            end
        end else if (cfg_wren) begin
            for (int e = 0; e < NGCL; e++) begin
                if (cfg_addr == 3'(e)) begin
                    gcl_q[e] <= cfg_wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Gate schedule FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DISABLED;
            idx_q   <= 3'd0;
            timer_q <= 16'd0;
            gate_q  <= '1;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    gate_q <= '1;
                    if (cfg_enable) begin
                        state_q <= ST_RUN;
                        idx_q   <= 3'd0;
                        timer_q <= w_entry0[15:0];
                        gate_q  <= w_e0_mask;
                    end
                end
                ST_RUN: begin
                    if (!cfg_enable) begin
                        state_q <= ST_DISABLED;
                        idx_q   <= 3'd0;
                        timer_q <= 16'd0;
                        gate_q  <= '1;
                    end else if (timer_q == 16'd0) begin
                        // A slot lasts duration+1 cycles, so duration 0
                        // naturally gives a one-cycle slot.
                        idx_q   <= idx_d;
                        timer_q <= w_next_entry[15:0];
                        gate_q  <= w_next_mask;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_DISABLED;
                    gate_q  <= '1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Queue selection and staging register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rden_q <= '0;
            full_q <= 1'b0;
            data_q <= 16'd0;
            cnt_q  <= 32'd0;
        end else begin
            rden_q <= w_can_pick ? sel_d : '0;
            if (rden_q != '0) begin
                full_q <= 1'b1;
                data_q <= w_cap_data;
                cnt_q  <= cnt_q + 32'd1;
            end else if (full_q && rden_metadata) begin
                // data_q is left untouched so the output never glitches.
                full_q <= 1'b0;
            end
        end
    end

    assign q_rden         = rden_q;
    assign empty_metadata = !full_q;
    assign data_metadata  = data_q;
    assign gate_state     = gate_q;
    assign cnt_sched      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tsn_gate_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tsn_gate_sched
//  Purpose  : Directed self-checking bench for tsn_gate_sched. Queues are
//             modelled as show-ahead FIFOs whose bufferID is {queue, index}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tsn_gate_sched;

    localparam int NQ   = 4;
    localparam int NGCL = 8;

    logic            clk;
    logic            rst_n;
    logic [NQ-1:0]   q_empty;
    logic [NQ-1:0]   q_rden;
    logic [16*NQ-1:0] q_data;
    logic            empty_metadata;
    logic            rden_metadata;
    logic [15:0]     data_metadata;
    logic            cfg_wren;
    logic [2:0]      cfg_addr;
    logic [19:0]     cfg_wdata;
    logic [3:0]      cfg_len;
    logic            cfg_enable;
    logic [NQ-1:0]   gate_state;
    logic [31:0]     cnt_sched;

    int n_checks = 0;
    int n_errors = 0;

    // Queue model: head advances on the DUT pop, tail is set by stimulus.
    logic [11:0] head [NQ];
    logic [11:0] tail [NQ];
    logic        auto_pop;
    logic        man_pop;

    // Monitor state
    logic [15:0] popped [16];
    int          n_pop   = 0;
    int          cyc     = 0;
    int          last_rd = -100;
    int          min_gap = 1000;
    int          bad_hot = 0;

    tsn_gate_sched #(
        .NQ   (NQ),
        .NGCL (NGCL)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .q_empty        (q_empty),
        .q_rden         (q_rden),
        .q_data         (q_data),
        .empty_metadata (empty_metadata),
        .rden_metadata  (rden_metadata),
        .data_metadata  (data_metadata),
        .cfg_wren       (cfg_wren),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_len        (cfg_len),
        .cfg_enable     (cfg_enable),
        .gate_state     (gate_state),
        .cnt_sched      (cnt_sched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            q_empty[i]          = (head[i] >= tail[i]);
            q_data[16*i +: 16]  = {4'(i), head[i]};
        end
    end

    assign rden_metadata = auto_pop ? !empty_metadata : man_pop;

    initial begin
        for (int i = 0; i < NQ; i++) head[i] = 12'd0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NQ; i++) begin
            if (q_rden[i]) head[i] <= head[i] + 12'd1;
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (auto_pop && !empty_metadata && rden_metadata && n_pop < 16) begin
            popped[n_pop] <= data_metadata;
            n_pop         <= n_pop + 1;
        end
        if (q_rden != '0) begin
            if (!$onehot(q_rden)) bad_hot <= bad_hot + 1;
            if (cyc - last_rd < min_gap) min_gap <= cyc - last_rd;
            last_rd <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gcl_write(input logic [2:0] a, input logic [19:0] d);
        cfg_wren  = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_wren  = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_ids [9];
        exp_ids = '{16'h3002, 16'h3003, 16'h3004,
                    16'h2001, 16'h2002, 16'h2003,
                    16'h1000, 16'h1001, 16'h1002};

        rst_n      = 1'b0;
        cfg_wren   = 1'b0;
        cfg_addr   = 3'd0;
        cfg_wdata  = 20'd0;
        cfg_len    = 4'd2;
        cfg_enable = 1'b0;
        auto_pop   = 1'b0;
        man_pop    = 1'b0;
        for (int i = 0; i < NQ; i++) tail[i] = 12'd0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_q_rden",  32'(q_rden),         32'h0);
        check("rst_empty",   32'(empty_metadata), 32'h1);
        check("rst_data",    32'(data_metadata),  32'h0);
        check("rst_gate",    32'(gate_state),     32'hF);
        check("rst_cnt",     cnt_sched,           32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- gates open, queues 0 and 3 ----------------
        tail[0] = 12'd1;
        tail[3] = 12'd1;
        tick();
        check("A_rden_q3",   32'(q_rden),         32'h8);
        check("A_empty_b4",  32'(empty_metadata), 32'h1);
        tick();
        check("A_rden_off",  32'(q_rden),         32'h0);
        check("A_empty",     32'(empty_metadata), 32'h0);
        check("A_data",      32'(data_metadata),  32'h3000);
        check("A_cnt",       cnt_sched,           32'd1);
        tick();
        check("A_hold_rden", 32'(q_rden),         32'h0);
        man_pop = 1'b1;
        tick();
        man_pop = 1'b0;
        check("A_pop_empty", 32'(empty_metadata), 32'h1);
        check("A_no_refill", 32'(q_rden),         32'h0);
        tick();
        check("A_rden_q0",   32'(q_rden),         32'h1);
        tick();
        check("A_data_q0",   32'(data_metadata),  32'h0000);
        check("A_cnt2",      cnt_sched,           32'd2);
        man_pop = 1'b1;
        tick();
        man_pop = 1'b0;

        // ---------------- GCL sequence and wrap ----------------
        gcl_write(3'd0, {4'b0001, 16'd10});
        gcl_write(3'd1, {4'b1000, 16'd5});
        cfg_len = 4'd2;
        check("B_gate_dis",  32'(gate_state),     32'hF);
        cfg_enable = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick();
            check("B_slot0",  32'(gate_state),    32'h1);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check("B_slot1",  32'(gate_state),    32'h8);
        end
        tick();
        check("B_wrap",      32'(gate_state),     32'h1);

        // ---------------- closed gate blocks selection ----------------
        cfg_enable = 1'b0;
        tick();
        check("C_gate_dis",  32'(gate_state),     32'hF);
        gcl_write(3'd0, {4'b0011, 16'd3});
        gcl_write(3'd1, {4'b0100, 16'd20});
        cfg_enable = 1'b1;
        tick();
        check("C_gate0",     32'(gate_state),     32'h3);
        tail[2] = 12'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("C_blocked", 32'(q_rden),       32'h0);
        end
        tick();
        check("C_gate1",     32'(gate_state),     32'h4);
        check("C_not_yet",   32'(q_rden),         32'h0);
        tick();
        check("C_rden_q2",   32'(q_rden),         32'h4);
        tick();
        check("C_empty",     32'(empty_metadata), 32'h0);
        check("C_data",      32'(data_metadata),  32'h2000);
        check("C_cnt",       cnt_sched,           32'd3);

        // ---------------- staged entry survives gate close ----------------
        man_pop = 1'b1;
        tick();
        man_pop = 1'b0;
        check("D_popped",    32'(empty_metadata), 32'h1);
        cfg_enable = 1'b0;
        tick();
        cfg_len = 4'd1;
        gcl_write(3'd0, {4'b0001, 16'd2});
        tail[3] = 12'd2;
        tick();
        check("D_rden_q3",   32'(q_rden),         32'h8);
        tick();
        check("D_data",      32'(data_metadata),  32'h3001);
        check("D_cnt",       cnt_sched,           32'd4);
        cfg_enable = 1'b1;
        tick();
        check("D_gate",      32'(gate_state),     32'h1);
        tick();
        tick();
        check("D_hold_data", 32'(data_metadata),  32'h3001);
        check("D_hold_full", 32'(empty_metadata), 32'h0);
        check("D_gate_wrap", 32'(gate_state),     32'h1);
        man_pop = 1'b1;
        tick();
        man_pop = 1'b0;
        check("D_released",  32'(empty_metadata), 32'h1);

        // ---------------- back-to-back drain of three queues ----------------
        cfg_enable = 1'b0;
        tail[1] = 12'd3;
        tail[2] = 12'd4;
        tail[3] = 12'd5;
        auto_pop = 1'b1;
        for (int k = 0; k < 80 && n_pop < 9; k++) tick();
        auto_pop = 1'b0;
        check("E_pop_count", 32'(n_pop),          32'd9);
        for (int k = 0; k < 9; k++) begin
            check("E_order",  32'(popped[k]),     32'(exp_ids[k]));
        end
        check("E_min_gap",   32'(min_gap),        32'd3);
        check("E_onehot",    32'(bad_hot),        32'd0);
        check("E_cnt",       cnt_sched,           32'd13);
        tick();
        check("E_drained",   32'(empty_metadata), 32'h1);

        // ---------------- reset mid-transfer ----------------
        cfg_enable = 1'b1;
        tick();
        check("F_gate",      32'(gate_state),     32'h1);
        tail[0] = 12'd2;
        tick();
        tick();
        check("F_staged",    32'(empty_metadata), 32'h0);
        check("F_data",      32'(data_metadata),  32'h0001);
        check("F_cnt",       cnt_sched,           32'd14);
        rst_n = 1'b0;
        #1;
        check("F_async_empty", 32'(empty_metadata), 32'h1);
        check("F_async_cnt",   cnt_sched,           32'd0);
        check("F_async_gate",  32'(gate_state),     32'hF);
        check("F_async_rden",  32'(q_rden),         32'h0);
        check("F_async_data",  32'(data_metadata),  32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("F_post_gate", 32'(gate_state),     32'hF);
        check("F_post_rden", 32'(q_rden),         32'h0);
        check("F_post_empty",32'(empty_metadata), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
